// File: rtl/rv32i_lsu_pkg.sv
// Shared constants, state encoding and legality helper for the RV32I memory-stage LSU.
package rv32i_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size as carried to the load aligner (funct3[1:0]).
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    function automatic logic access_legal(input logic [2:0] f3, input logic is_store,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half from a bus word
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            SZ_B:    data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            SZ_H:    data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory-stage load/store unit: ready-handshaked data bus, store lane steering,
// load extension. Optional watchdog abort enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignedM,
    output logic        BusErrM,
    output logic        DBusReq,
    output logic        DBusWe,
    output logic [31:0] DBusAddr,
    output logic [31:0] DBusWData,
    output logic [3:0]  DBusBe,
    input  logic        DBusReady,
    input  logic [31:0] DBusRData
);

    lsu_state_e  state_q;
    logic        dbus_req_q, dbus_we_q, sign_q, bus_err_q;
    logic [31:0] dbus_addr_q, dbus_wdata_q, read_data_q;
    logic [3:0]  dbus_be_q;
    logic [1:0]  offset_q, size_q;

    logic        access, legal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_data;

    assign access = MemReadM | MemWriteM;
    assign legal  = access_legal(Funct3M, MemWriteM, ALUResultM[1:0]);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
        case (Funct3M[1:0])
            SZ_B: begin
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                be_d    = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = WriteDataM;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata_i  (DBusRData),
        .offset_i (offset_q),
        .size_i   (size_q),
        .sign_i   (sign_q),
        .data_o   (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_wdata_q <= '0;
            dbus_be_q    <= '0;
            offset_q     <= '0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            read_data_q  <= '0;
            bus_err_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access && legal) begin
                        state_q      <= BUSY;
                        dbus_req_q   <= 1'b1;
                        dbus_we_q    <= MemWriteM;
                        dbus_addr_q  <= {ALUResultM[31:2], 2'b00};
                        dbus_wdata_q <= wdata_d;
                        dbus_be_q    <= be_d;
                        offset_q     <= ALUResultM[1:0];
                        size_q       <= Funct3M[1:0];
                        sign_q       <= ~Funct3M[2];
`ifdef LSU_TIMEOUT_EN
                        cnt_q        <= '0;
`endif
                    end else if (access) begin
                        read_data_q <= '0;
                    end
                end
                BUSY: begin
                    // A ready arriving on the timeout cycle still completes normally.
                    if (DBusReady) begin
                        dbus_req_q <= 1'b0;
                        state_q    <= DONE;
                        if (!dbus_we_q) begin
                            read_data_q <= load_data;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == TimeoutLast) begin
                        dbus_req_q  <= 1'b0;
                        read_data_q <= '0;
                        bus_err_q   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset so an access held in MEM cannot stall the pipe while RST is low.
    assign StallM      = RST & (((state_q == IDLE) & access & legal) | (state_q == BUSY));
    assign MisalignedM = RST & (state_q == IDLE) & access & ~legal;

    assign ReadDataM = read_data_q;
    assign BusErrM   = bus_err_q;
    assign DBusReq   = dbus_req_q;
    assign DBusWe    = dbus_we_q;
    assign DBusAddr  = dbus_addr_q;
    assign DBusWData = dbus_wdata_q;
    assign DBusBe    = dbus_be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu; covers the watchdog path when LSU_TIMEOUT_EN is defined.
module tb_mem_stage_lsu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignedM, BusErrM;
    logic        DBusReq, DBusWe;
    logic [31:0] DBusAddr, DBusWData;
    logic [3:0]  DBusBe;
    logic        DBusReady;
    logic [31:0] DBusRData;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    mem_stage_lsu #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .Funct3M     (Funct3M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ReadDataM   (ReadDataM),
        .StallM      (StallM),
        .MisalignedM (MisalignedM),
        .BusErrM     (BusErrM),
        .DBusReq     (DBusReq),
        .DBusWe      (DBusWe),
        .DBusAddr    (DBusAddr),
        .DBusWData   (DBusWData),
        .DBusBe      (DBusBe),
        .DBusReady   (DBusReady),
        .DBusRData   (DBusRData)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
        DBusReady  = 1'b0;
    endtask

    // One complete legal access; ready is raised after `waits` extra BUSY cycles.
    task automatic acc(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdat,
                       input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wdat;
        DBusRData  = rdat;
        DBusReady  = 1'b0;
        #1;
        chk({tag, "_idle_stall"}, 32'(StallM), 32'd1);
        chk({tag, "_idle_mis"}, 32'(MisalignedM), 32'd0);
        tick;
        chk({tag, "_busy_req"}, 32'(DBusReq), 32'd1);
        chk({tag, "_busy_stall"}, 32'(StallM), 32'd1);
        chk({tag, "_busy_we"}, 32'(DBusWe), 32'(wr));
        chk({tag, "_busy_addr"}, DBusAddr, exp_addr);
        chk({tag, "_busy_be"}, 32'(DBusBe), 32'(exp_be));
        if (wr) chk({tag, "_busy_wdata"}, DBusWData, exp_wdata);
        for (int i = 0; i < waits; i++) begin
            tick;
            chk({tag, "_wait_req"}, 32'(DBusReq), 32'd1);
            chk({tag, "_wait_stall"}, 32'(StallM), 32'd1);
        end
        DBusReady = 1'b1;
        tick;
        chk({tag, "_done_stall"}, 32'(StallM), 32'd0);
        chk({tag, "_done_req"}, 32'(DBusReq), 32'd0);
        chk({tag, "_done_rdata"}, ReadDataM, exp_rdata);
        chk({tag, "_done_buserr"}, 32'(BusErrM), 32'd0);
        clear_inputs();
        tick;
        chk({tag, "_after_stall"}, 32'(StallM), 32'd0);
        chk({tag, "_after_rdata"}, ReadDataM, exp_rdata);
    endtask

    // Illegal access: flagged combinationally, no bus cycle, ReadDataM cleared.
    task automatic bad_acc(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        #1;
        chk({tag, "_mis"}, 32'(MisalignedM), 32'd1);
        chk({tag, "_stall"}, 32'(StallM), 32'd0);
        tick;
        chk({tag, "_req"}, 32'(DBusReq), 32'd0);
        chk({tag, "_rdata"}, ReadDataM, 32'd0);
        chk({tag, "_stall2"}, 32'(StallM), 32'd0);
        clear_inputs();
        tick;
        chk({tag, "_req2"}, 32'(DBusReq), 32'd0);
        chk({tag, "_mis_clr"}, 32'(MisalignedM), 32'd0);
    endtask

    initial begin
        RST       = 1'b0;
        DBusRData = '0;
        clear_inputs();
        tick;
        chk("rst_req", 32'(DBusReq), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_be", 32'(DBusBe), 32'd0);
        chk("rst_addr", DBusAddr, 32'd0);
        chk("rst_buserr", 32'(BusErrM), 32'd0);
        tick;
        RST = 1'b1;
        tick;

        acc("lw",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,
            32'hDEADBEEF);
        acc("lb",  1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b1000, 32'h0,
            32'hFFFFFF80);
        acc("lbu", 1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b1000, 32'h0,
            32'h00000080);
        acc("lh",  1, 0, 3'b001, 32'h202, 32'h0, 32'h80FF7F01, 1, 32'h200, 4'b1100, 32'h0,
            32'hFFFF80FF);
        acc("lhu", 1, 0, 3'b101, 32'h202, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b1100, 32'h0,
            32'h000080FF);
        acc("lb1", 1, 0, 3'b000, 32'h201, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b0010, 32'h0,
            32'h0000007F);
        acc("lh0", 1, 0, 3'b001, 32'h200, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b0011, 32'h0,
            32'h00007F01);
        // Stores leave ReadDataM at the last load value.
        acc("sb",  0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0, 32'h300, 4'b0010,
            32'hA5A5A5A5, 32'h00007F01);
        acc("sh",  0, 1, 3'b001, 32'h302, 32'h00001234, 32'h0, 0, 32'h300, 4'b1100,
            32'h12341234, 32'h00007F01);
        acc("sw",  0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 32'h304, 4'b1111,
            32'hCAFEF00D, 32'h00007F01);
        acc("rdwr", 1, 1, 3'b000, 32'h400, 32'h0000005A, 32'hFFFFFFFF, 0, 32'h400, 4'b0001,
            32'h5A5A5A5A, 32'h00007F01);

        bad_acc("mis_lw", 1, 0, 3'b010, 32'h102);
        acc("lw2", 1, 0, 3'b010, 32'h108, 32'h0, 32'h2468ACE0, 0, 32'h108, 4'b1111, 32'h0,
            32'h2468ACE0);
        bad_acc("mis_lh", 1, 0, 3'b001, 32'h101);
        acc("lw3", 1, 0, 3'b010, 32'h10C, 32'h0, 32'h11223344, 0, 32'h10C, 4'b1111, 32'h0,
            32'h11223344);
        bad_acc("ill_sbu", 0, 1, 3'b100, 32'h300);
        bad_acc("ill_f3", 1, 0, 3'b011, 32'h300);

        // Reset on the 3rd BUSY cycle of a slow load.
        acc("lw4", 1, 0, 3'b010, 32'h110, 32'h0, 32'h55AA55AA, 0, 32'h110, 4'b1111, 32'h0,
            32'h55AA55AA);
        MemReadM   = 1'b1;
        Funct3M    = 3'b010;
        ALUResultM = 32'h400;
        DBusRData  = 32'h13579BDF;
        tick;
        chk("rstmid_busy_req", 32'(DBusReq), 32'd1);
        tick;
        tick;
        RST = 1'b0;
        #1;
        chk("rstmid_req", 32'(DBusReq), 32'd0);
        chk("rstmid_stall", 32'(StallM), 32'd0);
        chk("rstmid_rdata", ReadDataM, 32'd0);
        tick;
        RST = 1'b1;
        acc("rstmid_lw", 1, 0, 3'b010, 32'h400, 32'h0, 32'h13579BDF, 0, 32'h400, 4'b1111,
            32'h0, 32'h13579BDF);

`ifdef LSU_TIMEOUT_EN
        MemReadM   = 1'b1;
        Funct3M    = 3'b010;
        ALUResultM = 32'h500;
        DBusReady  = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("to_busy_req", 32'(DBusReq), 32'd1);
            tick;
        end
        chk("to_busy4_req", 32'(DBusReq), 32'd1);
        chk("to_busy4_err", 32'(BusErrM), 32'd0);
        tick;
        chk("to_done_err", 32'(BusErrM), 32'd1);
        chk("to_done_req", 32'(DBusReq), 32'd0);
        chk("to_done_rdata", ReadDataM, 32'd0);
        chk("to_done_stall", 32'(StallM), 32'd0);
        clear_inputs();
        tick;
        chk("to_idle_err", 32'(BusErrM), 32'd0);
        chk("to_idle_req", 32'(DBusReq), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit for the RV32I pipeline. It sits between the EX/MEM register and the MEM/WB register.
- Converts MemReadM/MemWriteM requests into a ready-handshaked data-bus transaction, with byte-lane steering for stores and sign/zero extension for loads.
- Drives ReadDataM into MEM/WB, and asserts StallM to the hazard unit while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit in BUSY cycles. Used only with LSU_TIMEOUT_EN.

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- Funct3M  in  3  access size/sign (RISC-V load/store funct3)
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data (rs2)
- ReadDataM  out  32  formatted load data, valid in DONE
- StallM  out  1  freeze IF..MEM and hold MEM/WB inputs
- MisalignedM  out  1  misaligned or illegal access flag
- BusErrM  out  1  watchdog abort flag (0 without feature)
- DBusReq  out  1  bus request
- DBusWe  out  1  1 = write
- DBusAddr  out  32  word-aligned address {addr[31:2],2'b00}
- DBusWData  out  32  lane-replicated store data
- DBusBe  out  4  byte enables
- DBusReady  in  1  slave completes transfer this cycle
- DBusRData  in  32  read data, valid with DBusReady

Behaviour:
- Reset (async, RST=0):
  - State goes to IDLE immediately.
  - DBusReq, DBusWe, DBusAddr, DBusWData, DBusBe, ReadDataM, BusErrM and the watchdog counter all become 0.
  - Reset mid-transaction drops DBusReq at once; the slave must tolerate this.
- Access definition: access = MemReadM | MemWriteM. If both are set, the access is a store.
- Legality:
  - Legal encodings: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - Halfword access needs addr[0]=0; word access needs addr[1:0]=00.
  - Any other encoding or alignment is illegal.
- IDLE state:
  - Legal access: StallM=1 (combinational). Register address, offset, size, sign, we, BE and WData. Go to BUSY.
  - Illegal access: MisalignedM=1 (combinational), StallM=0, ReadDataM is loaded with 0, no bus cycle, stay in IDLE.
- BUSY state:
  - DBusReq=1 and StallM=1.
  - All DBus outputs are held stable from registers until DBusReady.
  - On DBusReady: load data is formatted from DBusRData and the registered offset into ReadDataM (stores leave ReadDataM unchanged). Drop DBusReq. Go to DONE.
- DONE state:
  - StallM=0 for exactly one cycle; MEM/WB captures ReadDataM at this edge.
  - Go to IDLE.
  - The instruction now in MEM is evaluated in the following IDLE cycle, so back-to-back accesses are supported.
- Latency: at least 3 cycles per access (IDLE, BUSY with immediate ready, DONE); each extra wait state adds 1.
- Store steering:
  - SB: BE = 0001 << addr[1:0]; WData = the byte replicated 4 times.
  - SH: BE = 0011 << {addr[1],1'b0}; WData = the half replicated 2 times.
  - SW: BE = 1111; WData = WriteDataM.
- Load formatting:
  - Byte loads take lane addr[1:0]; halfword loads take half addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Non-access cycles: StallM=0, MisalignedM=0, ReadDataM holds its value.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without DBusReady.
  - When the counter reaches TIMEOUT_CYCLES, the access aborts: DBusReq drops, ReadDataM becomes 0, BusErrM=1 for one cycle, and the state goes to DONE.
  - DBusReady on the same cycle as the timeout takes priority and completes normally.
- Undefined: no counter exists, BUSY waits indefinitely, and BusErrM is tied to 0.

Decomposition:
- Package rv32i_lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state encoding (IDLE, BUSY, DONE)
  - the default TIMEOUT_CYCLES
- Sub-module lsu_load_align: purely combinational. It takes rdata, offset, size and sign and produces the extended 32-bit result, so it can be reused by a future instruction-side unit.

Test Plan:
- LW addr 0x100, DBusReady on 1st BUSY cycle, rdata 0xDEADBEEF -> StallM high 2 cycles then low 1 cycle; DBusAddr=0x100, DBusBe=1111; ReadDataM=0xDEADBEEF in DONE.
- LB addr 0x203, rdata 0x80FF7F01 -> ReadDataM=0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x202 -> 0xFFFF80FF.
- SB addr 0x301 data 0x000000A5 -> DBusWe=1, DBusBe=0010, DBusWData=0xA5A5A5A5. SH addr 0x302 data 0x1234 -> DBusBe=1100, DBusWData=0x12341234.
- LW addr 0x102, and separately LH addr 0x101 -> MisalignedM=1, DBusReq never rises, StallM=0, ReadDataM=0.
- LW with DBusReady delayed 5 cycles, RST pulsed low on 3rd BUSY cycle -> DBusReq=0 and StallM=0 immediately; after release, state is IDLE and the next LW completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and DBusReady held 0 -> abort after 4 BUSY cycles; BusErrM pulses 1 cycle, ReadDataM=0, then DONE followed by IDLE.
